// File: rtl/cust_serial_decoder.sv
// rtl/cust_serial_decoder.sv - line-code decoder with LSB-first word deserializer and one-entry output register
// Optional feature macro: CUST_DEC_PARITY_EN (even-parity slot after each word, par_err pulse on mismatch).
module cust_serial_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             overrun,
    output logic             par_err
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef CUST_DEC_PARITY_EN
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

    logic             a;
    logic             b;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;

    logic             start;
    logic             a_cur;
    logic             b_cur;
    logic             x;
    logic             complete;
    logic [CW-1:0]    cnt_cur;
    logic [WIDTH-1:0] shreg_cur;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] deliver;

    // A start-of-frame bit is decoded as if the state, counter and partial word were already cleared.
    always_comb begin
        start     = in_valid & sof;
        a_cur     = start ? 1'b0 : a;
        b_cur     = start ? 1'b0 : b;
        cnt_cur   = start ? '0 : cnt;
        shreg_cur = start ? '0 : shreg;
        x         = in_bit ^ a_cur ^ b_cur;
        word      = shreg_cur;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_cur == CW'(i)) begin
                word[i] = x;
            end
        end
        complete = in_valid & (cnt_cur == LAST);
`ifdef CUST_DEC_PARITY_EN
        deliver = shreg_cur;
`else
        deliver = word;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a         <= 1'b0;
            b         <= 1'b0;
            cnt       <= '0;
            shreg     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (in_valid) begin
                a     <= b_cur;
                b     <= ~(a_cur ^ x);
                cnt   <= complete ? '0 : cnt_cur + 1'b1;
                shreg <= complete ? '0 : word;
            end
            // A consumer taking the held word in the completion cycle frees the slot for the new one.
            if (complete && (!out_valid || out_ready)) begin
                out_valid <= 1'b1;
                out_data  <= deliver;
            end else if (complete) begin
                overrun <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CUST_DEC_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            par_err <= 1'b0;
        end else begin
            par_err <= complete & (x ^ (^shreg_cur));
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_cust_serial_decoder.sv
// tb/tb_cust_serial_decoder.sv - vector table plus encoder-driven scoreboard for cust_serial_decoder
module tb_cust_serial_decoder;
    localparam int WIDTH = 8;
`ifdef CUST_DEC_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_bit;
    logic       sof;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       overrun;
    logic       par_err;

    always #5 clk = ~clk;

    cust_serial_decoder #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .sof(sof),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .overrun(overrun), .par_err(par_err)
    );

    typedef struct {
        logic       iv;
        logic       sf;
        logic       bt;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic       eo;
        logic       ep;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb_q[$];
    int         checks = 0;
    int         fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, sf, bt, rdy, ev, input logic [7:0] ed, input logic eo, ep);
        vec_t v;
        v.iv = iv; v.sf = sf; v.bt = bt; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.eo = eo; v.ep = ep;
        vecs.push_back(v);
    endtask

    // Line bits of 0xC9 decode to 0xA5 from state (0,0) and return to (0,0); parity line bit p decodes to p.
    task automatic add_c9(input logic sf, rdy, ev_prior, gap, eo_last, pbit);
        logic [7:0] line;
        logic       last;
        line = 8'hC9;
        for (int i = 0; i < 8; i++) begin
            if (gap && i == 5) begin
                for (int g = 0; g < 3; g++) add(1'b0, 1'b0, 1'b0, rdy, ev_prior, 8'hA5, 1'b0, 1'b0);
            end
            last = (i == 7) && (PAR == 0);
            add(1'b1, sf && (i == 0), line[i], rdy, last ? 1'b1 : ev_prior, 8'hA5,
                last ? eo_last : 1'b0, 1'b0);
        end
        if (PAR != 0) add(1'b1, 1'b0, pbit, rdy, 1'b1, 8'hA5, eo_last, pbit);
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            in_valid  = vecs[i].iv;
            sof       = vecs[i].sf;
            in_bit    = vecs[i].bt;
            out_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d] out_valid", tag, i), out_valid, vecs[i].ev);
            if (vecs[i].ev) check($sformatf("%s[%0d] out_data", tag, i), out_data, vecs[i].ed);
            check($sformatf("%s[%0d] overrun", tag, i), overrun, vecs[i].eo);
            check($sformatf("%s[%0d] par_err", tag, i), par_err, vecs[i].ep);
        end
        vecs.delete();
    endtask

    task automatic sb_step();
        @(posedge clk);
        #1;
        if (out_valid) begin
            if (sb_q.size() == 0) check("sb unexpected word", 1, 0);
            else check("sb out_data", out_data, sb_q.pop_front());
        end
        check("sb overrun", overrun, 0);
    endtask

    initial begin
        logic       ea, eb, xb, y, nb;
        logic [7:0] data;
        reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; sof = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset overrun", overrun, 0);
        check("reset par_err", par_err, 0);
        reset = 1'b0;

        add_c9(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        run_vecs("basic");

        add_c9(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        run_vecs("gapped");

        add_c9(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_c9(PAR != 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        run_vecs("backpressure");

        for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        add_c9(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        run_vecs("resync");

        for (int i = 0; i < 5; i++) add(1'b1, i == 0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        run_vecs("pre_reset");
        reset = 1'b1;
        in_valid = 1'b1;
        in_bit = 1'b1;
        @(posedge clk);
        #1;
        check("midreset out_valid", out_valid, 0);
        check("midreset out_data", out_data, 0);
        check("midreset overrun", overrun, 0);
        check("midreset par_err", par_err, 0);
        reset = 1'b0;
        add_c9(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        run_vecs("post_reset");

        if (PAR != 0) begin
            add_c9(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            run_vecs("parity_bad");
        end

        // Random words through a reference encoder; out_ready stays high so every valid cycle is a new word.
        ea = 1'b0; eb = 1'b0;
        out_ready = 1'b1;
        for (int w = 0; w < 8; w++) begin
            data = 8'($urandom);
            for (int i = 0; i < WIDTH + PAR; i++) begin
                if (w == 0 && i == 0) begin ea = 1'b0; eb = 1'b0; end
                xb = (i < WIDTH) ? data[i] : ^data;
                y  = xb ^ ea ^ eb;
                nb = ~(ea ^ xb);
                ea = eb;
                eb = nb;
                in_valid = 1'b1;
                sof      = (w == 0 && i == 0);
                in_bit   = y;
                if (i == WIDTH + PAR - 1) sb_q.push_back(data);
                sb_step();
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    sof      = 1'b0;
                    sb_step();
                end
            end
        end
        in_valid = 1'b0;
        sof = 1'b0;
        repeat (4) sb_step();
        check("sb queue drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
